// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states, WB event kinds, trap causes.
// The hazard rule is selected by PIPELINE_CTRL_FORWARDING_EN (see hazard_detect).
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SLEEP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        EVT_NONE = 2'd0,
        EVT_TRAP = 2'd1,
        EVT_MRET = 2'd2,
        EVT_WFI  = 2'd3
    } evt_kind_t;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
    localparam logic [3:0] CAUSE_ECALL   = 4'd11;

    function automatic logic [4:0] make_cause(input logic intr, input logic [3:0] code);
        return {intr, code};
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational RAW check at decode. PIPELINE_CTRL_FORWARDING_EN defined: only load-use
// in execute stalls; otherwise any in-flight writer of a decode source stalls.
module hazard_detect (
    input  logic       dec_valid,
    input  logic [4:0] dec_rs1,
    input  logic [4:0] dec_rs2,
    input  logic       ex_valid,
    input  logic       ex_load,
    input  logic [4:0] ex_rd,
    input  logic       mem_valid,
    input  logic [4:0] mem_rd,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    output logic       hazard
);

    // x0 is hard-wired zero, so a write to it never produces a dependency.
    function automatic logic src_match(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
        return (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

`ifdef PIPELINE_CTRL_FORWARDING_EN
    logic unused_stage_info;
    assign unused_stage_info = ^{mem_valid, mem_rd, wb_valid, wb_rd};

    assign hazard = dec_valid && ex_valid && ex_load && src_match(ex_rd, dec_rs1, dec_rs2);
`else
    logic unused_load_flag;
    assign unused_load_flag = ex_load;

    assign hazard = dec_valid &&
                    ((ex_valid  && src_match(ex_rd,  dec_rs1, dec_rs2)) ||
                     (mem_valid && src_match(mem_rd, dec_rs1, dec_rs2)) ||
                     (wb_valid  && src_match(wb_rd,  dec_rs1, dec_rs2)));
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencer: stalls/invalidates, branch redirect, WB trap/MRET/WFI commit.
// Hazard rule depends on PIPELINE_CTRL_FORWARDING_EN (default build: no forwarding).
//
// state | meaning
// RUN   | normal flow; WB events, branches, bus stalls and hazards resolved here
// DRAIN | WB event latched, waiting for the outstanding bus transaction to finish
// SLEEP | after WFI; fetch held until an interrupt is pending
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dec_valid,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_target,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic        mem_busy,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_next_pc,
    input  logic        wb_exception,
    input  logic [3:0]  wb_ecause,
    input  logic        wb_mret,
    input  logic        wb_wfi,
    input  logic        irq_pending,
    input  logic        irq_take,
    input  logic [3:0]  irq_cause,
    input  logic [31:0] csr_mepc,
    input  logic [31:0] csr_mtvec,
    output logic        stall_fetch,
    output logic        stall_decode,
    output logic        stall_execute,
    output logic        stall_memory,
    output logic        invalidate_fetch,
    output logic        invalidate_decode,
    output logic        invalidate_execute,
    output logic        invalidate_memory,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        trap_valid,
    output logic [31:0] trap_epc,
    output logic [4:0]  trap_cause,
    output logic        mret_valid,
    output logic        sleeping
);

    state_t      state, state_n;
    evt_kind_t   evt_kind, evt_kind_n;
    logic [31:0] evt_epc, evt_epc_n;
    logic [4:0]  evt_cause, evt_cause_n;
    logic [31:0] wake_pc, wake_pc_n;

    logic        hazard;
    logic        wb_evt;
    evt_kind_t   wb_kind;
    logic [31:0] wb_epc;
    logic [4:0]  wb_cause;

    logic        exec;
    evt_kind_t   x_kind;
    logic [31:0] x_epc;
    logic [4:0]  x_cause;
    logic [31:0] x_wake;

    hazard_detect u_hazard (
        .dec_valid (dec_valid),
        .dec_rs1   (dec_rs1),
        .dec_rs2   (dec_rs2),
        .ex_valid  (ex_valid),
        .ex_load   (ex_load),
        .ex_rd     (ex_rd),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .hazard    (hazard)
    );

    // Exception beats interrupt, interrupt beats MRET/WFI.
    assign wb_evt = wb_valid && (wb_exception || wb_mret || wb_wfi || irq_take);

    always_comb begin
        wb_kind  = EVT_WFI;
        wb_epc   = wb_pc;
        wb_cause = 5'd0;
        if (wb_exception) begin
            wb_kind  = EVT_TRAP;
            wb_cause = make_cause(1'b0, wb_ecause);
        end else if (irq_take) begin
            wb_kind  = EVT_TRAP;
            wb_epc   = wb_next_pc;
            wb_cause = make_cause(1'b1, irq_cause);
        end else if (wb_mret) begin
            wb_kind  = EVT_MRET;
        end
    end

    always_comb begin
        stall_fetch        = 1'b0;
        stall_decode       = 1'b0;
        stall_execute      = 1'b0;
        stall_memory       = 1'b0;
        invalidate_fetch   = 1'b0;
        invalidate_decode  = 1'b0;
        invalidate_execute = 1'b0;
        invalidate_memory  = 1'b0;
        redirect           = 1'b0;
        redirect_pc        = 32'd0;
        trap_valid         = 1'b0;
        trap_epc           = 32'd0;
        trap_cause         = 5'd0;
        mret_valid         = 1'b0;
        sleeping           = 1'b0;
        state_n            = state;
        evt_kind_n         = evt_kind;
        evt_epc_n          = evt_epc;
        evt_cause_n        = evt_cause;
        wake_pc_n          = wake_pc;
        exec               = 1'b0;
        x_kind             = wb_kind;
        x_epc              = wb_epc;
        x_cause            = wb_cause;
        x_wake             = wb_next_pc;

        if (!reset) begin
            invalidate_fetch   = 1'b1;
            invalidate_decode  = 1'b1;
            invalidate_execute = 1'b1;
            invalidate_memory  = 1'b1;
            redirect           = 1'b1;
            redirect_pc        = RESET_VECTOR;
        end else begin
            case (state)
                ST_RUN: begin
                    if (wb_evt) begin
                        if (mem_busy) begin
                            stall_fetch       = 1'b1;
                            stall_decode      = 1'b1;
                            stall_execute     = 1'b1;
                            stall_memory      = 1'b1;
                            invalidate_memory = 1'b1;
                            state_n           = ST_DRAIN;
                            evt_kind_n        = wb_kind;
                            evt_epc_n         = wb_epc;
                            evt_cause_n       = wb_cause;
                            if (wb_kind == EVT_WFI)
                                wake_pc_n = wb_next_pc;
                        end else begin
                            exec = 1'b1;
                        end
                    end else if (ex_valid && ex_branch_taken) begin
                        redirect          = 1'b1;
                        redirect_pc       = ex_target;
                        invalidate_fetch  = 1'b1;
                        invalidate_decode = 1'b1;
                    end else if (mem_busy) begin
                        stall_fetch       = 1'b1;
                        stall_decode      = 1'b1;
                        stall_execute     = 1'b1;
                        stall_memory      = 1'b1;
                        invalidate_memory = 1'b1;
                    end else if (hazard) begin
                        stall_fetch       = 1'b1;
                        invalidate_decode = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (mem_busy) begin
                        stall_fetch       = 1'b1;
                        stall_decode      = 1'b1;
                        stall_execute     = 1'b1;
                        stall_memory      = 1'b1;
                        invalidate_memory = 1'b1;
                    end else begin
                        exec    = 1'b1;
                        x_kind  = evt_kind;
                        x_epc   = evt_epc;
                        x_cause = evt_cause;
                        x_wake  = wake_pc;
                    end
                end
                ST_SLEEP: begin
                    stall_fetch      = 1'b1;
                    invalidate_fetch = 1'b1;
                    sleeping         = 1'b1;
                    if (irq_pending)
                        state_n = ST_RUN;
                    if (irq_take) begin
                        redirect    = 1'b1;
                        redirect_pc = csr_mtvec;
                        trap_valid  = 1'b1;
                        trap_epc    = wake_pc;
                        trap_cause  = make_cause(1'b1, irq_cause);
                        state_n     = ST_RUN;
                    end
                end
                default: state_n = ST_RUN;
            endcase

            if (exec) begin
                invalidate_fetch   = 1'b1;
                invalidate_decode  = 1'b1;
                invalidate_execute = 1'b1;
                invalidate_memory  = 1'b1;
                redirect           = 1'b1;
                state_n            = ST_RUN;
                case (x_kind)
                    EVT_TRAP: begin
                        redirect_pc = csr_mtvec;
                        trap_valid  = 1'b1;
                        trap_epc    = x_epc;
                        trap_cause  = x_cause;
                    end
                    EVT_MRET: begin
                        redirect_pc = csr_mepc;
                        mret_valid  = 1'b1;
                    end
                    default: begin
                        redirect_pc = x_wake;
                        wake_pc_n   = x_wake;
                        state_n     = ST_SLEEP;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_RUN;
            evt_kind  <= EVT_NONE;
            evt_epc   <= 32'd0;
            evt_cause <= 5'd0;
            wake_pc   <= 32'd0;
        end else begin
            state     <= state_n;
            evt_kind  <= evt_kind_n;
            evt_epc   <= evt_epc_n;
            evt_cause <= evt_cause_n;
            wake_pc   <= wake_pc_n;
        end
    end

endmodule
